// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths and buffer entry type for the fetch stage
package fetch_pkg;
    localparam int ADDR_W  = 9;
    localparam int INSTR_W = 16;
    localparam int DEPTH   = 2;
    localparam int ENTRY_W = ADDR_W + INSTR_W;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO with flush and same-cycle push/pop
module fetch_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage is cleared on reset so the head reads as zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: issues PC to instruction memory, buffers words for decode
module instr_fetch
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc_addr,
    output logic               pc_en,
    output logic               pc_branch_en,
    output logic [ADDR_W-1:0]  pc_next_addr,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               branch_req,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_addr
);
    localparam int OCC_W = CNT_W + 1;

    logic [CNT_W-1:0]  count;
    logic [OCC_W-1:0]  occupancy;
    logic              inflight;
    logic              inflight_kill;
    logic [ADDR_W-1:0] inflight_addr;
    logic              branch;
    logic              issue;
    logic              pop;
    logic              push;
    fetch_entry_t      head;
    fetch_entry_t      push_entry;

    // Outputs stay quiet while reset is held, even though rst is asynchronous.
    always_comb begin
        branch       = branch_req & ~rst;
        instr_valid  = (count != '0) & ~branch;
        pop          = instr_valid & instr_ready;
        occupancy    = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
        issue        = ~rst & ~branch_req & (occupancy < OCC_W'(DEPTH));
        push         = inflight & ~inflight_kill & ~branch;
        imem_req     = issue;
        imem_addr    = pc_addr;
        pc_en        = issue | branch;
        pc_branch_en = branch;
        pc_next_addr = branch ? branch_target : '0;
        push_entry   = '{addr: inflight_addr, instr: imem_rdata};
        instr_data   = head.instr;
        instr_addr   = head.addr;
    end

    // No issue happens on a branch cycle, so the kill flag is only a guard
    // against a response surfacing in the cycle right after a redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight      <= 1'b0;
            inflight_kill <= 1'b0;
            inflight_addr <= '0;
        end else begin
            inflight      <= issue;
            inflight_kill <= branch;
            if (issue) begin
                inflight_addr <= pc_addr;
            end
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (branch),
        .head      (head),
        .count     (count)
    );
endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch with PC and memory models
module tb_instr_fetch;
    import fetch_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic [ADDR_W-1:0]  pc_addr;
    logic               pc_en;
    logic               pc_branch_en;
    logic [ADDR_W-1:0]  pc_next_addr;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               branch_req;
    logic [ADDR_W-1:0]  branch_target;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr_data;
    logic [ADDR_W-1:0]  instr_addr;

    int total = 0;
    int bad   = 0;

    instr_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .pc_addr       (pc_addr),
        .pc_en         (pc_en),
        .pc_branch_en  (pc_branch_en),
        .pc_next_addr  (pc_next_addr),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .branch_req    (branch_req),
        .branch_target (branch_target),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_data    (instr_data),
        .instr_addr    (instr_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [INSTR_W-1:0] mem_f(input logic [ADDR_W-1:0] a);
        return {a[6:0], a} ^ 16'h5A3C;
    endfunction

    // Program counter: increments or loads on pc_en.
    always @(posedge clk or posedge rst) begin
        if (rst) pc_addr <= '0;
        else if (pc_en) pc_addr <= pc_branch_en ? pc_next_addr : pc_addr + 1'b1;
    end

    // Synchronous memory; garbage when not read so unrequested pushes show up.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? mem_f(imem_addr) : INSTR_W'($urandom);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                rdy;
    } item_t;

    item_t             q[$];
    logic [ADDR_W-1:0] exp_pc = '0;
    int                cyc = 0;

    // Model: every issued address becomes visible two cycles later, in order;
    // a branch or reset throws away everything issued so far.
    always @(negedge clk) begin
        bit exp_valid;
        bit pop;
        bit exp_issue;
        if (rst) begin
            chk("rst_valid", instr_valid, 0);
            chk("rst_req", imem_req, 0);
            chk("rst_pc_en", pc_en, 0);
            chk("rst_br_en", pc_branch_en, 0);
            chk("rst_next", pc_next_addr, 0);
            chk("rst_iaddr", instr_addr, 0);
            chk("rst_idata", instr_data, 0);
            q.delete();
            exp_pc = '0;
        end else begin
            exp_valid = !branch_req && q.size() > 0 && q[0].rdy <= cyc;
            chk("m_valid", instr_valid, exp_valid);
            if (exp_valid) begin
                chk("m_addr", instr_addr, q[0].addr);
                chk("m_data", instr_data, mem_f(q[0].addr));
            end
            pop = exp_valid && instr_ready;
            exp_issue = !branch_req && (q.size() - int'(pop) < DEPTH);
            chk("m_req", imem_req, exp_issue);
            chk("m_pc_en", pc_en, exp_issue || branch_req);
            chk("m_br_en", pc_branch_en, branch_req);
            chk("m_next", pc_next_addr, branch_req ? branch_target : 0);
            chk("m_imem_addr", imem_addr, pc_addr);
            if (exp_issue) chk("m_issue_addr", imem_addr, exp_pc);
            if (branch_req) begin
                q.delete();
                exp_pc = branch_target;
            end else begin
                if (pop) void'(q.pop_front());
                if (exp_issue) begin
                    q.push_back('{addr: exp_pc, rdy: cyc + 2});
                    exp_pc = exp_pc + 1'b1;
                end
            end
        end
        cyc++;
    end

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_head(input string name, input logic [ADDR_W-1:0] a);
        @(negedge clk);
        chk({name, "_v"}, instr_valid, 1);
        chk({name, "_a"}, instr_addr, a);
    endtask

    initial begin
        int issues;
        rst = 1'b1; instr_ready = 1'b0; branch_req = 1'b0; branch_target = '0;
        repeat (3) go();
        @(negedge clk);
        chk("reset_valid", instr_valid, 0);
        chk("reset_req", imem_req, 0);
        chk("reset_data", instr_data, 0);

        // Streaming from reset with decode always ready.
        go(); rst = 1'b0; instr_ready = 1'b1;
        @(negedge clk);
        chk("t1_first_issue", imem_req, 1);
        chk("t1_first_addr", imem_addr, 0);
        go(); @(negedge clk); chk("t1_not_yet", instr_valid, 0);
        go(); expect_head("t1_0", 9'h000);
        go(); expect_head("t1_1", 9'h001);
        go(); expect_head("t1_2", 9'h002);

        // Backpressure from the start.
        go(); rst = 1'b1; instr_ready = 1'b0;
        go(); go(); rst = 1'b0;
        issues = 0;
        repeat (6) begin
            @(negedge clk);
            issues += int'(imem_req);
            go();
        end
        @(negedge clk);
        chk("t2_issues", issues, 2);
        chk("t2_pc_hold", pc_addr, 9'h002);
        chk("t2_valid", instr_valid, 1);
        chk("t2_head", instr_addr, 9'h000);
        go(); instr_ready = 1'b1; expect_head("t2_0", 9'h000);
        go(); expect_head("t2_1", 9'h001);
        go(); expect_head("t2_2", 9'h002);
        go(); expect_head("t2_3", 9'h003);

        // Branch with one buffered word and one fetch in flight, decode ready.
        go(); branch_req = 1'b1; branch_target = 9'h1F0;
        @(negedge clk);
        chk("t3_valid_low", instr_valid, 0);
        chk("t3_br_en", pc_branch_en, 1);
        chk("t3_next", pc_next_addr, 9'h1F0);
        chk("t3_no_issue", imem_req, 0);
        go(); branch_req = 1'b0; branch_target = '0;
        @(negedge clk);
        chk("t3_tgt_issue", imem_req, 1);
        chk("t3_tgt_addr", imem_addr, 9'h1F0);
        go(); @(negedge clk); chk("t3_gap", instr_valid, 0);
        go(); expect_head("t3_0", 9'h1F0);
        go(); expect_head("t3_1", 9'h1F1);

        // Wrap through the top of the address space.
        go(); branch_req = 1'b1; branch_target = 9'h1FE;
        go(); branch_req = 1'b0;
        go();
        go(); expect_head("t5_0", 9'h1FE);
        go(); expect_head("t5_1", 9'h1FF);
        go(); expect_head("t5_2", 9'h000);
        go(); expect_head("t5_3", 9'h001);

        // Reset mid-stream.
        go(); rst = 1'b1;
        @(negedge clk);
        chk("t6_valid", instr_valid, 0);
        chk("t6_addr", instr_addr, 0);
        chk("t6_data", instr_data, 0);
        chk("t6_pc_en", pc_en, 0);
        go(); rst = 1'b0;
        go();
        go(); expect_head("t6_0", 9'h000);
        chk("t6_d0", instr_data, mem_f(9'h000));

        // Randomized traffic checked by the model.
        for (int i = 0; i < 3000; i++) begin
            go();
            instr_ready   = ($urandom % 10) < 7;
            branch_req    = ($urandom % 20) == 0;
            branch_target = (($urandom % 4) == 0) ? 9'h1F8 + ADDR_W'($urandom % 8)
                                                  : ADDR_W'($urandom);
            rst           = ($urandom % 300) == 0;
        end
        go(); branch_req = 1'b0; rst = 1'b0; instr_ready = 1'b1;
        repeat (5) go();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
